// File: rtl/axis_upsizer_pkg.sv
// axis_upsizer shared types and widths.
// Narrow lane type plus the power-of-two ratio helper.
package axis_upsizer_pkg;

  localparam int AXIS_NARROW_BITS = 64;
  localparam int AXI_DATA_BITS    = 512;

  typedef logic [AXIS_NARROW_BITS-1:0] narrow_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// AXI4-Stream bundle without tlast/tkeep.
// Modport m drives data, modport s consumes it.
interface axis_upsizer_if #(
  parameter int DATA_BITS = 64
) ();

  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport m (
    output tdata,
    output tvalid,
    input  tready
  );

  modport s (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI4S beats into one wide beat.
// Flush emits a zero-padded partial word.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter  int S_BITS = AXIS_NARROW_BITS,
  parameter  int M_BITS = AXI_DATA_BITS,
  localparam int RATIO  = M_BITS / S_BITS,
  localparam int CW     = $clog2(RATIO)
) (
  input  logic          aclk,
  input  logic          aresetn,
  axis_upsizer_if.s     s_axis,
  axis_upsizer_if.m     m_axis,
  input  logic          flush,
  output logic          flush_ack,
  output logic [CW-1:0] fill_cnt
);

  if (!is_pow2(RATIO) || (M_BITS % S_BITS) != 0)
  begin : g_bad_ratio
    $error("axis_upsizer: bad width ratio");
  end

  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]     fill_q, fill_d;
  logic [S_BITS-1:0] pack_q [RATIO-1];
  logic [S_BITS-1:0] pack_d [RATIO-1];
  logic [M_BITS-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              ack_q, ack_d;

  logic              free;
  logic              last;
  logic              s_rdy;
  logic              s_hs;
  logic              emit;
  logic [M_BITS-1:0] word;

  assign free  = !vld_q || m_axis.tready;
  assign last  = (fill_q == LAST);
  assign s_rdy = !last || free;
  assign s_hs  = s_axis.tvalid && s_rdy;

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tdata  = data_q;
  assign flush_ack     = ack_q;
  assign fill_cnt      = fill_q;

  always_comb begin
    word   = '0;
    pack_d = pack_q;
    fill_d = fill_q;
    vld_d  = vld_q && !m_axis.tready;
    data_d = data_q;
    ack_d  = flush && free;
    emit   = (s_hs && last) ||
             (flush && free && (s_hs || fill_q != '0));

    for (int i = 0; i < RATIO - 1; i++) begin
      if (CW'(i) < fill_q)
        word[i*S_BITS +: S_BITS] = pack_q[i];
    end
    if (s_hs)
      word[fill_q*S_BITS +: S_BITS] = s_axis.tdata;

    if (s_hs && !last)
      pack_d[fill_q] = s_axis.tdata;

    if (emit) begin
      fill_d = '0;
      vld_d  = 1'b1;
      data_d = word;
    end else if (s_hs) begin
      fill_d = fill_q + CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fill_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ack_q  <= 1'b0;
      for (int i = 0; i < RATIO - 1; i++)
        pack_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      ack_q  <= ack_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed table, reset-mid-word and random
// scoreboard checks for axis_upsizer (64 -> 512).
module tb_axis_upsizer;
  import axis_upsizer_pkg::*;

  typedef struct {
    logic          sv;
    narrow_t       sd;
    logic          mr;
    logic          fl;
    logic          e_sr;
    logic          e_mv;
    logic [511:0]  e_md;
    logic          e_ack;
    logic [2:0]    e_fill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       flush_ack;
  logic [2:0] fill_cnt;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  axis_upsizer_if #(.DATA_BITS(64))  s_if ();
  axis_upsizer_if #(.DATA_BITS(512)) m_if ();

  axis_upsizer dut (
    .aclk      (clk),
    .aresetn   (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .flush     (flush),
    .flush_ack (flush_ack),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] ws(
    input logic [63:0] b,
    input int          n
  );
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < n; k++)
      w[k*64 +: 64] = b + 64'(k);
    return w;
  endfunction

  task automatic chk(
    input string        nm,
    input logic [511:0] act,
    input logic [511:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic    sv,
    input narrow_t sd,
    input logic    mr,
    input logic    fl
  );
    s_if.tvalid = sv;
    s_if.tdata  = sd;
    m_if.tready = mr;
    flush       = fl;
  endtask

  task automatic add(
    input logic         sv,
    input narrow_t      sd,
    input logic         mr,
    input logic         fl,
    input logic         esr,
    input logic         emv,
    input logic [511:0] emd,
    input logic         eack,
    input int           efill
  );
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl;
    v.e_sr = esr; v.e_mv = emv; v.e_md = emd;
    v.e_ack = eack; v.e_fill = 3'(efill);
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // random-phase reference state
  logic [63:0]  ml [8];
  int           mfill;
  logic         mvld;
  logic [511:0] mword;
  logic         mack;
  int           beats;
  int           cyc;

  initial begin
    drive(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", 512'(m_if.tvalid), 512'(0));
    chk("rst_mdata", m_if.tdata, 512'(0));
    chk("rst_ack", 512'(flush_ack), 512'(0));
    chk("rst_fill", 512'(fill_cnt), 512'(0));
    step();
    rst_n = 1'b1;

    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 'hA, 1, 0, 1, 0, 0, 0, 0);
    add(1, 'hB, 1, 0, 1, 0, 0, 0, 1);
    add(1, 'hC, 1, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 1, 1, 0, 0, 0, 3);
    add(0, 0, 1, 0, 1, 1, ws('hA, 3), 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 'hA, 1, 0, 1, 0, 0, 0, 0);
    add(1, 'hB, 1, 0, 1, 0, 0, 0, 1);
    add(1, 'hC, 1, 0, 1, 0, 0, 0, 2);
    add(1, 'hD, 1, 1, 1, 0, 0, 0, 3);
    add(0, 0, 1, 0, 1, 1, ws('hA, 4), 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 64'(k), 1, 0, 1, 0, 0, 0, k);
    add(1, 8, 0, 0, 1, 1, ws(0, 8), 0, 0);
    for (int k = 9; k < 15; k++)
      add(1, 64'(k), 0, 0, 1, 1, ws(0, 8), 0, k - 8);
    add(1, 15, 0, 0, 0, 1, ws(0, 8), 0, 7);
    add(1, 15, 1, 0, 1, 1, ws(0, 8), 0, 7);
    add(0, 0, 1, 0, 1, 1, ws(8, 8), 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 64'('h40 + k), 1, 0, 1, 0, 0, 0, k);
    add(1, 'h50, 0, 1, 1, 1, ws('h40, 8), 0, 0);
    add(0, 0, 0, 1, 1, 1, ws('h40, 8), 0, 1);
    add(0, 0, 1, 1, 1, 1, ws('h40, 8), 0, 1);
    add(0, 0, 1, 0, 1, 1, ws('h50, 1), 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("row%0d_srdy", i),
          512'(s_if.tready), 512'(tbl[i].e_sr));
      chk($sformatf("row%0d_mvld", i),
          512'(m_if.tvalid), 512'(tbl[i].e_mv));
      if (tbl[i].e_mv)
        chk($sformatf("row%0d_mdata", i),
            m_if.tdata, tbl[i].e_md);
      chk($sformatf("row%0d_ack", i),
          512'(flush_ack), 512'(tbl[i].e_ack));
      chk($sformatf("row%0d_fill", i),
          512'(fill_cnt), 512'(tbl[i].e_fill));
      step();
    end

    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 64'('h100 + k), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_mvalid", 512'(m_if.tvalid), 512'(0));
    chk("mid_rst_mdata", m_if.tdata, 512'(0));
    chk("mid_rst_ack", 512'(flush_ack), 512'(0));
    chk("mid_rst_fill", 512'(fill_cnt), 512'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 64'('h200 + k), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_mvld", 512'(m_if.tvalid), 512'(1));
    chk("post_rst_word", m_if.tdata, ws('h200, 8));
    chk("post_rst_fill", 512'(fill_cnt), 512'(0));
    step();
    @(negedge clk);
    chk("post_rst_idle", 512'(m_if.tvalid), 512'(0));
    step();

    mfill = 0;
    mvld  = 1'b0;
    mword = '0;
    mack  = 1'b0;
    beats = 0;
    cyc   = 0;
    for (int k = 0; k < 8; k++) ml[k] = '0;
    while (beats < 10000 && cyc < 60000) begin
      logic sv, mr, fl, esr, free, hs;
      narrow_t sd;
      int nf;
      sv = ($urandom_range(0, 9) < 7);
      mr = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 31) == 0);
      sd = {$urandom(), $urandom()};
      drive(sv, sd, mr, fl);
      @(negedge clk);
      free = !mvld || mr;
      esr  = (mfill != 7) || free;
      chk("rnd_srdy", 512'(s_if.tready), 512'(esr));
      chk("rnd_mvld", 512'(m_if.tvalid), 512'(mvld));
      if (mvld)
        chk("rnd_mdata", m_if.tdata, mword);
      chk("rnd_ack", 512'(flush_ack), 512'(mack));
      chk("rnd_fill", 512'(fill_cnt), 512'(mfill));
      hs = sv && esr;
      if (mvld && mr) mvld = 1'b0;
      nf = mfill;
      if (hs) begin
        ml[mfill] = sd;
        nf = mfill + 1;
        beats++;
      end
      if (nf == 8 || (fl && free && nf != 0)) begin
        mword = '0;
        for (int k = 0; k < nf; k++)
          mword[k*64 +: 64] = ml[k];
        mvld  = 1'b1;
        mfill = 0;
      end else begin
        mfill = nf;
      end
      mack = fl && free;
      step();
      cyc++;
    end
    chk("rnd_beats_done", 512'(beats), 512'(10000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
